// File: rtl/l2_cache_control.sv
// l2_cache_control: controller for a 2-way write-back L2 cache.
// Accepts one request at a time from the I/D arbiter, resolves hit/miss,
// writes back a dirty victim, refills the line from physical memory and
// then re-runs the lookup so the response always comes from the array.
//
// Optional feature: define L2_PERF_CNT_EN to add saturating hit_count and
// miss_count outputs (CNT_WIDTH bits each). Without the macro the counter
// ports and logic are absent and the FSM behaves identically.
//
// Handshake: the arbiter raises mem_read/mem_write and holds it until
// mem_resp, which is a single-cycle pulse in the CHECK state. The pmem side
// is level-based: pmem_read/pmem_write stay high until pmem_resp is seen,
// and the transfer completes in the cycle pmem_resp=1.
//
// fsm_state exposes the controller state for debug and checker binding
// (0 = IDLE, 1 = CHECK, 2 = WRITEBACK, 3 = ALLOCATE).

module l2_cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 lru,
  input  logic                 victim_dirty,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic                 way_sel,
  output logic                 data_load,
  output logic                 data_src_sel,
  output logic                 tag_load,
  output logic                 valid_load,
  output logic                 dirty_load,
  output logic                 dirty_in,
  output logic                 lru_load,
  output logic                 lru_in,
  output logic                 pmem_addr_sel,
  output logic [1:0]           fsm_state
`ifdef L2_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Request decode. A simultaneous read and write is handled as a write;
  // when both ways report a hit, way 0 wins.
  logic req;
  logic is_write;
  logic hit;
  logic hit_way;

  assign req      = mem_read | mem_write;
  assign is_write = mem_write;
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0 & hit1;

  assign fsm_state = state;

  // State register with asynchronous reset back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (!req) begin
          // Request withdrawn: abandon without a response.
          state_next = IDLE;
        end else if (hit) begin
          state_next = IDLE;
        end else if (victim_dirty) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        // After the refill, go back to CHECK so the lookup hits the new line.
        if (pmem_resp) begin
          state_next = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: everything defaults low, and nothing is driven during reset
  // so pmem strobes drop in the same cycle rst rises.
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_sel       = 1'b0;
    data_load     = 1'b0;
    data_src_sel  = 1'b0;
    tag_load      = 1'b0;
    valid_load    = 1'b0;
    dirty_load    = 1'b0;
    dirty_in      = 1'b0;
    lru_load      = 1'b0;
    lru_in        = 1'b0;
    pmem_addr_sel = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
        end
        CHECK: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            // The hit way becomes MRU, so lru points at the other way.
            lru_load = 1'b1;
            lru_in   = ~hit_way;
            if (is_write) begin
              data_load    = 1'b1;
              data_src_sel = 1'b0;
              dirty_load   = 1'b1;
              dirty_in     = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = lru;
        end
        ALLOCATE: begin
          pmem_read     = 1'b1;
          pmem_addr_sel = 1'b0;
          way_sel       = lru;
          if (pmem_resp) begin
            data_load    = 1'b1;
            data_src_sel = 1'b1;
            tag_load     = 1'b1;
            valid_load   = 1'b1;
            dirty_load   = 1'b1;
            dirty_in     = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef L2_PERF_CNT_EN
  // A request that missed and was refilled comes back through CHECK; the
  // filled flag keeps that second lookup from being counted again.
  logic filled;
  logic count_hit;
  logic count_miss;

  assign count_hit  = (state == CHECK) && req && hit && !filled;
  assign count_miss = (state == CHECK) && req && !hit && !filled;

  // Saturating performance counters and the per-request refill marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filled     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == ALLOCATE && pmem_resp) begin
        filled <= 1'b1;
      end else if (state_next == IDLE) begin
        filled <= 1'b0;
      end
      if (count_hit && (hit_count != {CNT_WIDTH{1'b1}})) begin
        hit_count <= hit_count + CNT_WIDTH'(1);
      end
      if (count_miss && (miss_count != {CNT_WIDTH{1'b1}})) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end
`else
  // Counter width only matters when the counters exist; keep the parameter
  // referenced so both builds share one interface.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed testbench for l2_cache_control: reset values, read/write hits,
// priority cases, clean and dirty misses with refill, withdrawn request,
// reset during ALLOCATE, and (with L2_PERF_CNT_EN) counter saturation.

module tb_l2_cache_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write, mem_resp;
  logic       hit0, hit1, lru, victim_dirty;
  logic       pmem_read, pmem_write, pmem_resp;
  logic       way_sel, data_load, data_src_sel, tag_load, valid_load;
  logic       dirty_load, dirty_in, lru_load, lru_in, pmem_addr_sel;
  logic [1:0] fsm_state;
`ifdef L2_PERF_CNT_EN
  logic [1:0] hit_count, miss_count;
`endif

  int total = 0;
  int bad   = 0;

  // Output vector, MSB first:
  // mem_resp pmem_read pmem_write way_sel data_load data_src_sel tag_load
  // valid_load dirty_load dirty_in lru_load lru_in pmem_addr_sel
  logic [12:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, way_sel, data_load,
                 data_src_sel, tag_load, valid_load, dirty_load, dirty_in,
                 lru_load, lru_in, pmem_addr_sel};

  localparam logic [12:0] O_NONE      = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] O_RHIT1     = 13'b1_0_0_1_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] O_RHIT0     = 13'b1_0_0_0_0_0_0_0_0_0_1_1_0;
  localparam logic [12:0] O_WHIT0     = 13'b1_0_0_0_1_0_0_0_1_1_1_1_0;
  localparam logic [12:0] O_WHIT1     = 13'b1_0_0_1_1_0_0_0_1_1_1_0_0;
  localparam logic [12:0] O_ALLOC1    = 13'b0_1_0_1_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] O_ALLOC0    = 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] O_FILL1     = 13'b0_1_0_1_1_1_1_1_1_0_0_0_0;
  localparam logic [12:0] O_FILL0     = 13'b0_1_0_0_1_1_1_1_1_0_0_0_0;
  localparam logic [12:0] O_WB0       = 13'b0_0_1_0_0_0_0_0_0_0_0_0_1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;
  localparam logic [1:0] S_ALLOC = 2'd3;

  l2_cache_control #(.CNT_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_resp      (mem_resp),
    .hit0          (hit0),
    .hit1          (hit1),
    .lru           (lru),
    .victim_dirty  (victim_dirty),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_resp     (pmem_resp),
    .way_sel       (way_sel),
    .data_load     (data_load),
    .data_src_sel  (data_src_sel),
    .tag_load      (tag_load),
    .valid_load    (valid_load),
    .dirty_load    (dirty_load),
    .dirty_in      (dirty_in),
    .lru_load      (lru_load),
    .lru_in        (lru_in),
    .pmem_addr_sel (pmem_addr_sel),
    .fsm_state     (fsm_state)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_outs(input string tag, input logic [12:0] exp);
    total++;
    assert (outs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    total++;
    assert (fsm_state === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, fsm_state, exp);
    end
  endtask

  task automatic chk_val(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One hit request from IDLE: response in the cycle after IDLE, then back
  // to IDLE with no second response.
  task automatic hit_req(input string tag, input logic rd, input logic wr,
                         input logic h0, input logic h1,
                         input logic [12:0] exp);
    mem_read = rd; mem_write = wr; hit0 = h0; hit1 = h1;
    #1;
    chk_outs({tag, "_idle"}, O_NONE);
    tick();
    chk_state({tag, "_check"}, S_CHECK);
    chk_outs({tag, "_resp"}, exp);
    tick();
    chk_state({tag, "_done"}, S_IDLE);
    mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    #1;
    chk_outs({tag, "_quiet"}, O_NONE);
  endtask

  int rd_cycles;
  int wr_cycles;
  int overlap;

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    lru = 1'b0; victim_dirty = 1'b0; pmem_resp = 1'b0;
    #1;
    chk_outs("reset_outs", O_NONE);
    chk_state("reset_state", S_IDLE);
    // Request pending during reset must not move the FSM.
    mem_read = 1'b1;
    tick();
    chk_state("reset_hold", S_IDLE);
    chk_outs("reset_hold_outs", O_NONE);
    mem_read = 1'b0;
    rst = 1'b0;
    tick();
    chk_state("post_reset_idle", S_IDLE);

    // Hits
    hit_req("read_hit1", 1'b1, 1'b0, 1'b0, 1'b1, O_RHIT1);
    hit_req("write_hit0", 1'b0, 1'b1, 1'b1, 1'b0, O_WHIT0);
    hit_req("write_hit1", 1'b0, 1'b1, 1'b0, 1'b1, O_WHIT1);
    hit_req("read_both_hits", 1'b1, 1'b0, 1'b1, 1'b1, O_RHIT0);
    hit_req("rw_both_hits", 1'b1, 1'b1, 1'b1, 1'b1, O_WHIT0);

    // Clean miss, victim way 1, pmem_resp on the 5th ALLOCATE cycle
    mem_read = 1'b1; lru = 1'b1; victim_dirty = 1'b0;
    tick();
    chk_state("clean_check", S_CHECK);
    chk_outs("clean_check_outs", O_NONE);
    tick();
    rd_cycles = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) pmem_resp = 1'b1;
      #1;
      if (pmem_read) rd_cycles++;
      chk_state("clean_alloc_state", S_ALLOC);
      chk_outs("clean_alloc_outs", (i == 5) ? O_FILL1 : O_ALLOC1);
      tick();
      pmem_resp = 1'b0;
    end
    chk_val("clean_pmem_read_cycles", rd_cycles, 5);
    chk_state("clean_recheck", S_CHECK);
    hit1 = 1'b1;
    #1;
    chk_outs("clean_resp", O_RHIT1);
    tick();
    chk_state("clean_done", S_IDLE);
    mem_read = 1'b0; hit1 = 1'b0; lru = 1'b0;
    #1;
    chk_outs("clean_quiet", O_NONE);

    // Dirty miss, victim way 0: writeback 3 cycles, then refill 2 cycles
    mem_write = 1'b1; lru = 1'b0; victim_dirty = 1'b1;
    tick();
    chk_state("dirty_check", S_CHECK);
    chk_outs("dirty_check_outs", O_NONE);
    tick();
    wr_cycles = 0; rd_cycles = 0; overlap = 0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) pmem_resp = 1'b1;
      #1;
      if (pmem_write) wr_cycles++;
      if (pmem_read && pmem_write) overlap++;
      chk_state("dirty_wb_state", S_WB);
      chk_outs("dirty_wb_outs", O_WB0);
      tick();
      pmem_resp = 1'b0;
    end
    victim_dirty = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      if (i == 2) pmem_resp = 1'b1;
      #1;
      if (pmem_read) rd_cycles++;
      if (pmem_read && pmem_write) overlap++;
      chk_state("dirty_alloc_state", S_ALLOC);
      chk_outs("dirty_alloc_outs", (i == 2) ? O_FILL0 : O_ALLOC0);
      tick();
      pmem_resp = 1'b0;
    end
    chk_val("dirty_pmem_write_cycles", wr_cycles, 3);
    chk_val("dirty_pmem_read_cycles", rd_cycles, 2);
    chk_val("dirty_overlap", overlap, 0);
    chk_state("dirty_recheck", S_CHECK);
    hit0 = 1'b1;
    #1;
    chk_outs("dirty_resp", O_WHIT0);
    tick();
    chk_state("dirty_done", S_IDLE);
    mem_write = 1'b0; hit0 = 1'b0;
    #1;
    chk_outs("dirty_quiet", O_NONE);

    // Withdrawn request
    mem_read = 1'b1;
    tick();
    chk_state("withdraw_check", S_CHECK);
    mem_read = 1'b0;
    #1;
    chk_outs("withdraw_outs", O_NONE);
    tick();
    chk_state("withdraw_idle", S_IDLE);

    // Reset while ALLOCATE holds pmem_read
    mem_read = 1'b1; lru = 1'b1;
    tick();
    tick();
    #1;
    chk_state("rst_alloc_state", S_ALLOC);
    chk_outs("rst_alloc_outs", O_ALLOC1);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("rst_alloc_drop", O_NONE);
    chk_state("rst_alloc_idle", S_IDLE);
    mem_read = 1'b0; lru = 1'b0;
    tick();
    chk_state("rst_held", S_IDLE);
    rst = 1'b0;
    mem_read = 1'b1; hit0 = 1'b1;
    #1;
    chk_state("rst_release_idle", S_IDLE);
    tick();
    chk_state("rst_first_edge", S_CHECK);
    chk_outs("rst_first_resp", O_RHIT0);
    tick();
    mem_read = 1'b0; hit0 = 1'b0;
    #1;
    chk_state("rst_seq_idle", S_IDLE);

`ifdef L2_PERF_CNT_EN
    // Counters: clear, 4 hits then one clean miss with refill
    rst = 1'b1;
    #1;
    chk_val("cnt_reset_hit", int'(hit_count), 0);
    chk_val("cnt_reset_miss", int'(miss_count), 0);
    tick();
    rst = 1'b0;
    tick();
    hit_req("cnt_hit_a", 1'b1, 1'b0, 1'b0, 1'b1, O_RHIT1);
    hit_req("cnt_hit_b", 1'b1, 1'b0, 1'b0, 1'b1, O_RHIT1);
    chk_val("cnt_hit_two", int'(hit_count), 2);
    hit_req("cnt_hit_c", 1'b1, 1'b0, 1'b0, 1'b1, O_RHIT1);
    hit_req("cnt_hit_d", 1'b1, 1'b0, 1'b0, 1'b1, O_RHIT1);
    mem_read = 1'b1; lru = 1'b0; victim_dirty = 1'b0;
    tick();
    tick();
    pmem_resp = 1'b1;
    #1;
    chk_outs("cnt_fill", O_FILL0);
    tick();
    pmem_resp = 1'b0;
    hit0 = 1'b1;
    #1;
    chk_outs("cnt_miss_resp", O_RHIT0);
    tick();
    mem_read = 1'b0; hit0 = 1'b0;
    #1;
    chk_val("cnt_hit_sat", int'(hit_count), 3);
    chk_val("cnt_miss", int'(miss_count), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
